// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_NACK,
        ST_STOP
    } i2c_mst_state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_LOW0  = 2'd0;
    localparam phase_t PH_LOW1  = 2'd1;
    localparam phase_t PH_HIGH0 = 2'd2;
    localparam phase_t PH_HIGH1 = 2'd3;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timing base: a tick every CLK_DIV clocks and a wrapping 2-bit phase.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   en,
    input  logic   clr,
    output logic   tick,
    output phase_t phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    phase_t        phase_q, phase_d;

    assign tick  = en && !clr && (div_q == CW'(CLK_DIV - 1));
    assign phase = phase_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        div_d   = div_q;
        phase_d = phase_q;
        if (clr) begin
            div_d   = '0;
            phase_d = PH_LOW0;
        end else if (tick) begin
            div_d   = '0;
            phase_d = phase_t'(phase_q + 2'd1);
        end else if (en) begin
            div_d = div_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            div_q   <= '0;
            phase_q <= PH_LOW0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte, STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int   CLK_DIV = 4,
    parameter logic ACK_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       i2c_scl,
    output logic       i2c_sda,
    input  logic       sda_in,
    output logic       m_stop
);

    i2c_mst_state_t state_q, state_d;
    logic           busy_q, done_q, ack_err_q, rw_q, samp_q;
    logic [7:0]     rdata_q, addr_byte_q, wdata_q, rx_q;
    logic [2:0]     bit_cnt_q;
    logic           tick, accept, bit_end, last_bit, reload;
    phase_t         phase;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (busy_q),
        .clr     (state_q == ST_IDLE),
        .tick    (tick),
        .phase   (phase)
    );

    assign accept   = start && !busy_q;
    assign bit_end  = tick && (phase == PH_HIGH1);
    assign last_bit = (bit_cnt_q == 3'd0);
    assign reload   = (state_d != state_q) &&
                      (state_d == ST_ADDR || state_d == ST_WR_DATA || state_d == ST_RD_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (busy_q) state_d = ST_START;
            ST_START:    if (bit_end) state_d = ST_ADDR;
            ST_ADDR:     if (bit_end && last_bit) state_d = ST_ADDR_ACK;
            ST_ADDR_ACK: if (bit_end) begin
                             if (samp_q == ACK_POL) state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
                             else                   state_d = ST_STOP;
                         end
            ST_WR_DATA:  if (bit_end && last_bit) state_d = ST_WR_ACK;
            ST_WR_ACK:   if (bit_end) state_d = ST_STOP;
            ST_RD_DATA:  if (bit_end && last_bit) state_d = ST_RD_NACK;
            ST_RD_NACK:  if (bit_end) state_d = ST_STOP;
            ST_STOP:     if (bit_end) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // START/STOP drive SDA while SCL is high; every other slot only changes SDA with SCL low.
    always_comb begin
        i2c_scl = 1'b1;
        i2c_sda = 1'b1;
        m_stop  = 1'b0;
        unique case (state_q)
            ST_START: begin
                i2c_scl = (phase != PH_HIGH1);
                i2c_sda = (phase == PH_LOW0) || (phase == PH_LOW1);
            end
            ST_ADDR: begin
                i2c_scl = (phase >= PH_HIGH0);
                i2c_sda = addr_byte_q[bit_cnt_q];
            end
            ST_WR_DATA: begin
                i2c_scl = (phase >= PH_HIGH0);
                i2c_sda = wdata_q[bit_cnt_q];
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_DATA: i2c_scl = (phase >= PH_HIGH0);
            ST_RD_NACK: begin
                i2c_scl = (phase >= PH_HIGH0);
                i2c_sda = ~ACK_POL;
            end
            ST_STOP: begin
                i2c_scl = (phase != PH_LOW0);
                i2c_sda = (phase >= PH_HIGH0);
                m_stop  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            addr_byte_q <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            samp_q      <= 1'b1;
            bit_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q      <= 1'b1;
                ack_err_q   <= 1'b0;
                rw_q        <= rw;
                addr_byte_q <= {addr, rw};
                wdata_q     <= wdata;
            end
            if (state_q == ST_STOP && bit_end) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            // Bus is sampled on the tick that enters the SCL-high half of the bit.
            if (tick && phase == PH_LOW1) begin
                samp_q <= sda_in;
                if (state_q == ST_RD_DATA) rx_q <= {rx_q[6:0], sda_in};
            end
            if (bit_end && (state_q == ST_ADDR_ACK || state_q == ST_WR_ACK) && samp_q != ACK_POL)
                ack_err_q <= 1'b1;
            if (bit_end && state_q == ST_RD_NACK) rdata_q <= rx_q;
            if (reload)       bit_cnt_q <= 3'(BITS_PER_BYTE - 1);
            else if (bit_end) bit_cnt_q <= bit_cnt_q - 3'd1;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: vector table with a slave bus model plus corner sequences.
module tb_i2c_master_ctrl;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rbyte;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
        logic [7:0] exp_abits;
        logic [7:0] exp_dbits;
        int         exp_rises;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, rw, busy, done, ack_err, i2c_scl, i2c_sda, sda_in, m_stop;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;

    logic       start2, rw2, busy2, done2, ack_err2, scl2, sda2, sda_in2, m_stop2, s2_val;
    logic [6:0] addr2;
    logic [7:0] wdata2, rdata2;

    int checks = 0;
    int errors = 0;

    i2c_master_ctrl #(.CLK_DIV(4), .ACK_POL(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .i2c_scl(i2c_scl), .i2c_sda(i2c_sda), .sda_in(sda_in), .m_stop(m_stop)
    );

    i2c_master_ctrl #(.CLK_DIV(1), .ACK_POL(1'b1)) dut_pol1 (
        .clk(clk), .reset_n(reset_n), .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .done(done2), .ack_err(ack_err2), .rdata(rdata2),
        .i2c_scl(scl2), .i2c_sda(sda2), .sda_in(sda_in2), .m_stop(m_stop2)
    );

    // Slave model: the bit slot index is the number of SCL falls seen since accept, minus one.
    logic       m_rw, m_ack_addr, m_ack_data, slv_sda;
    logic [7:0] m_rbyte;
    int         falls = 0, rises = 0, done_cnt = 0, mstop_cnt = 0;
    logic       prev_scl = 1'b1, prev_busy = 1'b0, prev_mstop = 1'b0, mstop_at_done = 1'b0;
    logic       rec_bus [32];
    logic       rec_mst [32];

    always_comb begin
        slv_sda = 1'b1;
        if (busy && falls > 0) begin
            if (falls == 9) slv_sda = ~m_ack_addr;
            else if (m_rw && m_ack_addr && falls >= 10 && falls <= 17) slv_sda = m_rbyte[17 - falls];
            else if (!m_rw && m_ack_addr && falls == 18) slv_sda = ~m_ack_data;
        end
    end

    assign sda_in  = i2c_sda & slv_sda;
    assign sda_in2 = sda2 & s2_val;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            falls     <= 0;
            rises     <= 0;
            mstop_cnt <= 0;
            done_cnt  <= 0;
            for (int i = 0; i < 32; i++) begin
                rec_bus[i] <= 1'bx;
                rec_mst[i] <= 1'bx;
            end
        end else begin
            if (busy && prev_scl && !i2c_scl) falls <= falls + 1;
            if (busy && !prev_scl && i2c_scl) begin
                rises <= rises + 1;
                if (falls > 0 && falls <= 32) begin
                    rec_bus[falls-1] <= sda_in;
                    rec_mst[falls-1] <= i2c_sda;
                end
            end
            if (busy && m_stop) mstop_cnt <= mstop_cnt + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (done_cnt == 0) mstop_at_done <= prev_mstop;
            end
        end
        prev_scl   <= i2c_scl;
        prev_busy  <= busy;
        prev_mstop <= m_stop;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no done pulse within the cycle budget", name);
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w);
        @(negedge clk);
        addr  = a;
        rw    = r;
        wdata = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns clocks from the accept edge to the clock in which done is high.
    task automatic wait_done(input int coll_at, output int lat);
        int t;
        t   = 0;
        lat = -1;
        while (lat < 0 && t < 4000) begin
            if (coll_at > 0 && t == coll_at) begin
                addr  = 7'h12;
                rw    = 1'b1;
                wdata = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
            if (t == 1) begin
                check("busy_after_accept", busy, 1'b1);
                check("ack_err_cleared", ack_err, 1'b0);
            end
            if (done) lat = t;
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int coll_at, input string tag);
        int         lat;
        logic [7:0] ab, db;
        m_rw       = v.rw;
        m_ack_addr = v.ack_addr;
        m_ack_data = v.ack_data;
        m_rbyte    = v.rbyte;
        issue(v.addr, v.rw, v.wdata);
        wait_done(coll_at, lat);
        if (lat < 0) timeout_fail({tag, "_done"});
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ab[7-i] = rec_bus[i];
            db[7-i] = rec_bus[9+i];
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_ack_err"}, ack_err, v.exp_err);
        check({tag, "_rdata"}, rdata, v.exp_rdata);
        check({tag, "_addr_bits"}, ab, v.exp_abits);
        check({tag, "_scl_rises"}, rises, v.exp_rises);
        if (v.exp_rises == 19) begin
            check({tag, "_data_bits"}, db, v.exp_dbits);
            check({tag, "_slot17_master_sda"}, rec_mst[17], 1'b1);
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_mstop_clks"}, mstop_cnt, 16);
        check({tag, "_mstop_before_done"}, mstop_at_done, 1'b1);
        check({tag, "_idle_bus"}, {busy, i2c_scl, i2c_sda, m_stop}, 4'b0110);
    endtask

    task automatic run2(input logic val, input int exp_lat, input logic exp_err, input string tag);
        int t, lat;
        s2_val = val;
        @(negedge clk);
        addr2  = 7'h54;
        rw2    = 1'b0;
        wdata2 = 8'hA5;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t      = 0;
        lat    = -1;
        while (lat < 0 && t < 1000) begin
            @(negedge clk);
            t++;
            if (done2) lat = t;
        end
        if (lat < 0) timeout_fail({tag, "_done"});
        repeat (5) @(negedge clk);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ack_err"}, ack_err2, exp_err);
        check({tag, "_idle"}, {busy2, scl2, sda2, m_stop2, rdata2}, {4'b0110, 8'h00});
    endtask

    vec_t vecs [6];
    vec_t cv;

    initial begin
        vecs[0] = '{7'h54, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 321, 8'hA8, 8'hA5, 19};
        vecs[1] = '{7'h54, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 321, 8'hA9, 8'h3C, 19};
        vecs[2] = '{7'h12, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 177, 8'h24, 8'h00, 10};
        vecs[3] = '{7'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h3C, 321, 8'h00, 8'h00, 19};
        vecs[4] = '{7'h3B, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 321, 8'h76, 8'h5A, 19};
        vecs[5] = '{7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81, 321, 8'hFF, 8'h81, 19};

        reset_n = 1'b0;
        {start, rw, addr, wdata} = '0;
        {start2, rw2, addr2, wdata2} = '0;
        s2_val = 1'b1;
        {m_rw, m_ack_addr, m_ack_data, m_rbyte} = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {i2c_scl, i2c_sda, busy, done, ack_err, m_stop, rdata},
              {6'b110000, 8'h00});
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 0, $sformatf("v%0d", i));

        // A second start 50 clocks in must leave the first command untouched.
        cv = vecs[0];
        cv.exp_rdata = 8'h81;
        run_vec(cv, 50, "collision");

        // Reset while SCL is low during address bit 3 (addr 0x12 puts a 0 on SDA there).
        m_rw = 1'b0;
        m_ack_addr = 1'b1;
        m_ack_data = 1'b1;
        issue(7'h12, 1'b0, 8'h00);
        repeat (86) @(negedge clk);
        check("pre_reset_bus", {busy, i2c_scl, i2c_sda}, 3'b100);
        #1 reset_n = 1'b0;
        #1 check("reset_mid_addr", {i2c_scl, i2c_sda, busy, m_stop, done, rdata}, {5'b11000, 8'h00});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 0, "after_reset");

        run2(1'b1, 81, 1'b0, "pol1_ack");
        run2(1'b0, 45, 1'b1, "pol1_nack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
